// File: rtl/vga_sync_gen_if.sv
// Raster bus between the VGA timing generator and the colour-producing blocks.
// The master drives coordinates, strobes and pins; the slave returns merged colour.
interface vga_sync_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       vga_on;
  logic       line_end;
  logic       frame_end;
  logic [7:0] frame_count;
  logic [2:0] rgb_in;
  logic [2:0] rgb_out;
  logic       hsync;
  logic       vsync;

  modport master (
    output x, y, vga_on, line_end, frame_end, frame_count, rgb_out, hsync, vsync,
    input  rgb_in
  );

  modport slave (
    input  x, y, vga_on, line_end, frame_end, frame_count, rgb_out, hsync, vsync,
    output rgb_in
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing: pixel counters, zero-latency decodes and a
// single output register stage keeping colour and sync aligned at the pins.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic      clk25M,
  input  logic      reset,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] FE_LINE  = 10'(V_VISIBLE + 1);

  logic [9:0] x;
  logic [9:0] y;
  logic [7:0] frame_count;
  logic       h_wrap;
  logic       v_wrap;
  logic       on;
  logic       h_active;
  logic       v_active;
  logic [2:0] rgb_q;
  logic       hsync_q;
  logic       vsync_q;

  assign h_wrap = (x == H_LAST);
  assign v_wrap = (y == V_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let y see the already-updated x.
  always_ff @(posedge clk25M or posedge reset) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
    end else if (h_wrap) begin
      x <= '0;
      if (v_wrap) begin
        y           <= '0;
        frame_count <= frame_count + 8'd1;
      end else begin
        y <= y + 10'd1;
      end
    end else begin
      x <= x + 10'd1;
    end
  end

  // Decodes of the current counter state, consumed the same cycle downstream.
  assign on       = (x < H_VIS) && (y < V_VIS);
  assign h_active = (x >= HS_START) && (x < HS_END);
  assign v_active = (y >= VS_START) && (y < VS_END);

  // Colour comes back combinationally for (x,y); registering it together with
  // the syncs puts both on the pins one cycle later, still aligned.
  always_ff @(posedge clk25M or posedge reset) begin
    if (reset) begin
      rgb_q   <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      rgb_q   <= on ? vga.rgb_in : 3'b000;
      hsync_q <= h_active ? SYNC_POL : ~SYNC_POL;
      vsync_q <= v_active ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.x           = x;
  assign vga.y           = y;
  assign vga.vga_on      = on;
  assign vga.line_end    = h_wrap;
  assign vga.frame_end   = (x == '0) && (y == FE_LINE);
  assign vga.frame_count = frame_count;
  assign vga.rgb_out     = rgb_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size timing for the first lines and an async
// reset, plus a shrunken raster run through 256+ frames against an arithmetic model.
module tb_vga_sync_gen;

  logic clk25M = 1'b0;
  logic rst_f  = 1'b1;
  logic rst_s  = 1'b1;

  int checks = 0;
  int passes = 0;

  vga_sync_if vf ();
  vga_sync_if vs ();

  vga_sync_gen dut_full (
    .clk25M (clk25M),
    .reset  (rst_f),
    .vga    (vf)
  );

  vga_sync_gen #(
    .H_VISIBLE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_VISIBLE (4), .V_FP (1), .V_SYNC (1), .V_BP (2),
    .SYNC_POL  (1'b1)
  ) dut_small (
    .clk25M (clk25M),
    .reset  (rst_s),
    .vga    (vs)
  );

  always #20 clk25M = ~clk25M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected state after n clock edges since reset release: x, y and the frame
  // number follow directly from n; pins reflect the state at n-1.
  task automatic model_check(
    input string tag, input int n,
    input int hv, input int hf, input int hs, input int hb,
    input int vv, input int vfp, input int vsy, input int vb,
    input bit pol, input logic [2:0] prev_rgb,
    input logic [9:0] ox, input logic [9:0] oy, input logic oon, input logic ole,
    input logic ofe, input logic [7:0] ofc, input logic [2:0] orgb,
    input logic ohs, input logic ovs
  );
    int ht, vt, ex, ey, px, py;
    bit pon, phs, pvs;
    ht = hv + hf + hs + hb;
    vt = vv + vfp + vsy + vb;
    ex = n % ht;
    ey = (n / ht) % vt;
    check({tag, ".x"}, 32'(ox), 32'(ex));
    check({tag, ".y"}, 32'(oy), 32'(ey));
    check({tag, ".vga_on"}, 32'(oon), 32'((ex < hv) && (ey < vv)));
    check({tag, ".line_end"}, 32'(ole), 32'(ex == ht - 1));
    check({tag, ".frame_end"}, 32'(ofe), 32'((ex == 0) && (ey == vv + 1)));
    check({tag, ".frame_count"}, 32'(ofc), 32'((n / (ht * vt)) % 256));
    if (n == 0) begin
      pon = 1'b0; phs = 1'b0; pvs = 1'b0;
    end else begin
      px  = (n - 1) % ht;
      py  = ((n - 1) / ht) % vt;
      pon = (px < hv) && (py < vv);
      phs = (px >= hv + hf) && (px < hv + hf + hs);
      pvs = (py >= vv + vfp) && (py < vv + vfp + vsy);
    end
    check({tag, ".rgb_out"}, 32'(orgb), pon ? 32'(prev_rgb) : 32'd0);
    check({tag, ".hsync"}, 32'(ohs), 32'(phs ? pol : !pol));
    check({tag, ".vsync"}, 32'(ovs), 32'(pvs ? pol : !pol));
  endtask

  task automatic check_full(input string tag, input int n, input logic [2:0] prev_rgb);
    model_check(tag, n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, prev_rgb,
                vf.x, vf.y, vf.vga_on, vf.line_end, vf.frame_end, vf.frame_count,
                vf.rgb_out, vf.hsync, vf.vsync);
  endtask

  task automatic check_small(input string tag, input int n, input logic [2:0] prev_rgb);
    model_check(tag, n, 8, 1, 2, 1, 4, 1, 1, 2, 1'b1, prev_rgb,
                vs.x, vs.y, vs.vga_on, vs.line_end, vs.frame_end, vs.frame_count,
                vs.rgb_out, vs.hsync, vs.vsync);
  endtask

  initial begin
    int n;
    int hits;
    logic [2:0] prev_rgb;

    vf.rgb_in = 3'b000;
    vs.rgb_in = 3'b000;
    prev_rgb  = 3'b000;

    // Reset state, then the first lines at full timing with random colour.
    @(negedge clk25M);
    check_full("full_reset", 0, prev_rgb);
    rst_f = 1'b0;
    n = 0;
    while (n < 2700) begin
      prev_rgb  = 3'($urandom);
      vf.rgb_in = prev_rgb;
      n++;
      @(negedge clk25M);
      check_full("full_run", n, prev_rgb);
    end

    // Now at (300,3): assert reset between edges; outputs drop immediately.
    check("pre_reset_x", 32'(vf.x), 32'd300);
    #5 rst_f = 1'b1;
    #1 check_full("async_reset", 0, prev_rgb);
    @(negedge clk25M);
    check_full("held_reset", 0, prev_rgb);
    rst_f = 1'b0;

    // Line 0 with constant white checks blanking; then a single marked pixel.
    n = 0;
    hits = 0;
    while (n < 2500) begin
      if (n < 800) prev_rgb = 3'b111;
      else prev_rgb = ((n % 800) == 5 && (n / 800) == 1) ? 3'b010 : 3'b000;
      vf.rgb_in = prev_rgb;
      n++;
      @(negedge clk25M);
      check_full("full_restart", n, prev_rgb);
      if (n > 800 && vf.rgb_out == 3'b010) hits++;
    end
    check("align_hits", 32'(hits), 32'd1);

    // Shrunken raster (96-clock frame, active-high syncs) through frame_count wrap.
    prev_rgb = 3'b000;
    check_small("small_reset", 0, prev_rgb);
    rst_s = 1'b0;
    n = 0;
    while (n < 256 * 96 + 150) begin
      prev_rgb  = 3'($urandom);
      vs.rgb_in = prev_rgb;
      n++;
      @(negedge clk25M);
      check_small("small_run", n, prev_rgb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock: one pixel per clk25M cycle.
- Outputs pixel coordinates x/y and the visible-area flag vga_on. Sprite and paddle blocks (e.g. ball) decode these combinationally to form their colour.
- Takes the merged pixel colour back as rgb_in. Drives the pins rgb_out/hsync/vsync one cycle later, so colour and sync stay aligned.
- Also provides frame_end and line_end strobes for game-state updates.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk25M  in  1  pixel clock, 25 MHz
- reset  in  1  asynchronous, active-high
- x  out  10  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- vga_on  out  1  high when x<H_VISIBLE and y<V_VISIBLE
- line_end  out  1  one-cycle strobe when x==H_TOTAL-1
- frame_end  out  1  one-cycle strobe when x==0 and y==V_VISIBLE+1
- frame_count  out  8  frames completed, wraps 255->0
- rgb_in  in  3  pixel colour for the current (x,y), combinational from downstream
- rgb_out  out  3  registered colour to DAC/pins
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Reset is asynchronous, active-high, clock clk25M. While reset is high:
  - x=0, y=0, frame_count=0.
  - rgb_out=0.
  - hsync=vsync=!SYNC_POL (inactive).
  - line_end=frame_end=0.
  - vga_on=1, because it decodes (0,0).
- Horizontal counter x increments every clock. At H_TOTAL-1 it wraps to 0 on the next clock.
- Vertical counter y increments only on the clock where x wraps. At V_TOTAL-1 it wraps to 0 together with x.
- frame_count increments on the clock where both counters wrap, i.e. (799,524)->(0,0). It is modulo 256.
- x and y are registers. vga_on, line_end and frame_end are combinational decodes of the current x/y (zero-latency with respect to x/y).
- hsync active region, decoded from x: H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
- vsync active region, decoded from y: V_VISIBLE+V_FP <= y < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491.
- Output pipeline: one register stage.
  - hsync, vsync and rgb_out at cycle t+1 reflect the counter state at cycle t.
  - rgb_out(t+1) = vga_on(t) ? rgb_in(t) : 3'b000. Colour outside the visible area is always forced black, regardless of rgb_in.
- Reset mid-frame: counters and outputs return to their reset values immediately (asynchronously). The raster restarts at (0,0) on the first clock edge after reset deasserts. No partial strobes are emitted during reset.
- The counters never exceed H_TOTAL-1 / V_TOTAL-1. There are no other states.
- Line period is exactly 800 clocks. Frame period is exactly 420000 clocks.

Test Plan:
- Reset release, then count clocks -> x follows 0,1,...,799,0. y steps 0->1 on the clock x goes 799->0. line_end is high only at x==799.
- Sync timing -> hsync first goes active 657 clocks after x==0 (one cycle after x==656) and stays active exactly 96 clocks. vsync is active for exactly 2 lines (1600 clocks), starting one clock after (x,y)=(0,490).
- Blanking -> drive rgb_in=3'b111 constantly. rgb_out=111 for cycles following x in 0..639 with y<480, and 000 for cycles following x>=640 or y>=480.
- Frame strobes -> frame_end pulses once per 420000 clocks, at (0,481). frame_count goes 0->1 at the (799,524)->(0,0) transition, and reaches 0 again after 256 frames.
- Reset asserted asynchronously at (x,y)=(300,200) between clock edges -> all outputs take their reset values before the next edge. After release, hsync first asserts 657 clocks after the first x==0 cycle.
- Pixel alignment -> rgb_in=3'b010 only when x==5 and y==7 -> rgb_out is 010 for exactly one cycle, the cycle after (5,7).
